// File: rtl/pin_debounce.sv
// Two-flop synchronised pin debouncer with a four-state qualification FSM.
// Optional single-cycle rise/fall pulses are built when PIN_DEBOUNCE_EDGE_EN is defined.
module pin_debounce #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16,
    parameter bit          RESET_VAL     = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_in,
    output logic d_out,
    output logic busy
`ifdef PIN_DEBOUNCE_EDGE_EN
    ,
    output logic rise_p,
    output logic fall_p
`endif
);

    // Encoding: bit 1 is the debounced level, bit 0 marks a qualification in progress.
    localparam logic [1:0] STABLE_LO   = 2'b00;
    localparam logic [1:0] WAIT_HI     = 2'b01;
    localparam logic [1:0] STABLE_HI   = 2'b10;
    localparam logic [1:0] WAIT_LO     = 2'b11;
    localparam logic [1:0] RESET_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic             s1;
    logic             s2;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             d_out_nxt;
    logic             busy_nxt;
`ifdef PIN_DEBOUNCE_EDGE_EN
    logic             rise_nxt;
    logic             fall_nxt;
`endif

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            STABLE_LO, STABLE_HI: begin
                if (s2 != d_out) begin
                    state_nxt = (state == STABLE_LO) ? WAIT_HI : WAIT_LO;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            WAIT_HI, WAIT_LO: begin
                if (s2 == d_out) begin
                    state_nxt = (state == WAIT_HI) ? STABLE_LO : STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt < CNT_MAX) begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end else begin
                    state_nxt = (state == WAIT_HI) ? STABLE_HI : STABLE_LO;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = RESET_STATE;
                cnt_nxt   = '0;
            end
        endcase
        d_out_nxt = state_nxt[1];
        busy_nxt  = state_nxt[0];
`ifdef PIN_DEBOUNCE_EDGE_EN
        rise_nxt  = (state == WAIT_HI) && (state_nxt == STABLE_HI);
        fall_nxt  = (state == WAIT_LO) && (state_nxt == STABLE_LO);
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1     <= RESET_VAL;
            s2     <= RESET_VAL;
            state  <= RESET_STATE;
            cnt    <= '0;
            d_out  <= RESET_VAL;
            busy   <= 1'b0;
`ifdef PIN_DEBOUNCE_EDGE_EN
            rise_p <= 1'b0;
            fall_p <= 1'b0;
`endif
        end else begin
            s1     <= raw_in;
            s2     <= s1;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            d_out  <= d_out_nxt;
            busy   <= busy_nxt;
`ifdef PIN_DEBOUNCE_EDGE_EN
            rise_p <= rise_nxt;
            fall_p <= fall_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pin_debounce.sv
// Directed bench for pin_debounce: one instance with STABLE_CYCLES=4/RESET_VAL=0,
// one with STABLE_CYCLES=1/RESET_VAL=1; edge pulses are checked when PIN_DEBOUNCE_EDGE_EN is defined.
module tb_pin_debounce;

    logic clock = 1'b0;
    logic reset_n;
    logic raw0, raw1;
    logic d0, busy0, d1, busy1;
    logic rise0, fall0, rise1, fall1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    pin_debounce #(.STABLE_CYCLES(4), .CNT_W(16), .RESET_VAL(1'b0)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .raw_in  (raw0),
        .d_out   (d0),
        .busy    (busy0)
`ifdef PIN_DEBOUNCE_EDGE_EN
        ,
        .rise_p  (rise0),
        .fall_p  (fall0)
`endif
    );

    pin_debounce #(.STABLE_CYCLES(1), .CNT_W(16), .RESET_VAL(1'b1)) u_dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .raw_in  (raw1),
        .d_out   (d1),
        .busy    (busy1)
`ifdef PIN_DEBOUNCE_EDGE_EN
        ,
        .rise_p  (rise1),
        .fall_p  (fall1)
`endif
    );

`ifndef PIN_DEBOUNCE_EDGE_EN
    assign rise0 = 1'b0;
    assign fall0 = 1'b0;
    assign rise1 = 1'b0;
    assign fall1 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive raw0 for one edge, then compare the first instance's outputs.
    task automatic step0(input logic r, input int e, input logic ed, input logic eb,
                         input logic er, input logic ef, input string sc);
        raw0 = r;
        tick();
        check($sformatf("%s e%0d d_out", sc, e), 32'(d0), 32'(ed));
        check($sformatf("%s e%0d busy", sc, e), 32'(busy0), 32'(eb));
`ifdef PIN_DEBOUNCE_EDGE_EN
        check($sformatf("%s e%0d rise_p", sc, e), 32'(rise0), 32'(er));
        check($sformatf("%s e%0d fall_p", sc, e), 32'(fall0), 32'(ef));
`endif
    endtask

    task automatic step1(input logic r, input int e, input logic ed, input logic eb,
                         input logic er, input logic ef, input string sc);
        raw1 = r;
        tick();
        check($sformatf("%s e%0d d_out", sc, e), 32'(d1), 32'(ed));
        check($sformatf("%s e%0d busy", sc, e), 32'(busy1), 32'(eb));
`ifdef PIN_DEBOUNCE_EDGE_EN
        check($sformatf("%s e%0d rise_p", sc, e), 32'(rise1), 32'(er));
        check($sformatf("%s e%0d fall_p", sc, e), 32'(fall1), 32'(ef));
`endif
    endtask

    initial begin
        // Reset with raw_in driven against the reset level: it must be ignored.
        reset_n = 1'b0;
        raw0    = 1'b1;
        raw1    = 1'b0;
        repeat (3) tick();
        check("rst d0", 32'(d0), 32'd0);
        check("rst busy0", 32'(busy0), 32'd0);
        check("rst cnt0", 32'(u_dut.cnt), 32'd0);
        check("rst d1", 32'(d1), 32'd1);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst rise0", 32'(rise0), 32'd0);
        check("rst fall1", 32'(fall1), 32'd0);

        reset_n = 1'b1;
        raw1    = 1'b1;
        for (int e = 1; e <= 4; e++) step0(1'b0, e, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

        // Clean rise: busy after edges 3..6, d_out after edge 7.
        for (int e = 1; e <= 8; e++)
            step0(1'b1, e, e >= 7, (e >= 3) && (e <= 6), e == 7, 1'b0, "rise");
        // Clean fall.
        for (int e = 1; e <= 8; e++)
            step0(1'b0, e, e < 7, (e >= 3) && (e <= 6), 1'b0, e == 7, "fall");
        // Three-cycle glitch is rejected.
        for (int e = 1; e <= 8; e++)
            step0(e <= 3, e, 1'b0, (e >= 3) && (e <= 5), 1'b0, 1'b0, "glitch");
        // Bounce 1,0,1,0 then hold 1 from edge 5.
        for (int e = 1; e <= 12; e++)
            step0((e == 1) || (e == 3) || (e >= 5), e, e >= 11,
                  (e == 3) || (e == 5) || ((e >= 7) && (e <= 10)), e == 11, 1'b0, "bounce");
        for (int e = 1; e <= 8; e++)
            step0(1'b0, e, e < 7, (e >= 3) && (e <= 6), 1'b0, e == 7, "fall2");

        // Reset mid-qualification with cnt = 3, then full re-qualification.
        for (int e = 1; e <= 5; e++)
            step0(1'b1, e, 1'b0, e >= 3, 1'b0, 1'b0, "midrst");
        check("midrst cnt before", 32'(u_dut.cnt), 32'd3);
        reset_n = 1'b0;
        step0(1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b0, "midrst");
        check("midrst cnt after", 32'(u_dut.cnt), 32'd0);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++)
            step0(1'b1, e, e >= 7, (e >= 3) && (e <= 6), e == 7, 1'b0, "requal");

        // STABLE_CYCLES=1, RESET_VAL=1 instance.
        check("inst1 d after rst", 32'(d1), 32'd1);
        for (int e = 1; e <= 6; e++)
            step1(1'b0, e, e < 4, e == 3, 1'b0, e == 4, "s1fall");
        for (int e = 1; e <= 6; e++)
            step1(1'b1, e, e >= 4, e == 3, e == 4, 1'b0, "s1rise");
        for (int e = 1; e <= 6; e++)
            step1(e != 1, e, 1'b1, e == 3, 1'b0, 1'b0, "s1pulse");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pin_debounce.md
PIN_DEBOUNCE -- requirements
Module: pin_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: number of consecutive stable synchronized samples required before the output changes; legal range 1..65535.
REQ-002 Parameter CNT_W, default 16: stability counter width; SHALL be able to hold STABLE_CYCLES.
REQ-003 Parameter RESET_VAL, default 0: reset level of all sample flops and of the debounced output.
REQ-004 Port clock  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1  synchronous reset, active low.
REQ-006 Port raw_in  input  1  asynchronous, bouncy level taken from one device pin.
REQ-007 Port d_out  output  1  registered, debounced level; drives the D input of the downstream registered pin stage.
REQ-008 Port busy  output  1  high while a candidate level change is being qualified.
REQ-009 Ports rise_p and fall_p  output  1 each  single-cycle edge pulses; present only with PIN_DEBOUNCE_EDGE_EN (see Configuration).

Function
REQ-010 Synchronizer: raw_in SHALL pass through two flops, s1 then s2, before any use; no logic between them.
REQ-011 FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO; d_out = 1 in STABLE_HI and WAIT_LO, 0 otherwise.
REQ-012 STABLE_x with s2 != d_out: go to WAIT_x, set cnt to 1.
REQ-013 STABLE_x with s2 == d_out: stay, cnt held at 0.
REQ-014 WAIT_x with s2 == d_out (bounce): return to the same STABLE_x, cnt to 0, d_out unchanged.
REQ-015 WAIT_x with s2 != d_out and cnt < STABLE_CYCLES: cnt increments by 1.
REQ-016 WAIT_x with s2 != d_out and cnt == STABLE_CYCLES: go to the opposite STABLE state (d_out toggles), cnt to 0.
REQ-017 cnt SHALL never exceed STABLE_CYCLES and SHALL never wrap.
REQ-018 Latency: a clean level change first sampled by s1 on edge k SHALL appear on d_out after edge k+STABLE_CYCLES+2, i.e. on the (STABLE_CYCLES+3)th sampling edge.
REQ-019 busy SHALL be 1 exactly in WAIT_HI and WAIT_LO.
REQ-020 A pulse on raw_in lasting fewer than STABLE_CYCLES+1 clock cycles, as seen at s2, SHALL NOT change d_out.
REQ-021 d_out SHALL toggle at most once per STABLE_CYCLES+1 cycles.

Reset
REQ-022 While reset_n = 0 at a rising edge: s1, s2 and d_out take RESET_VAL; state takes STABLE_LO if RESET_VAL = 0, else STABLE_HI; cnt = 0; busy = 0; rise_p = fall_p = 0.
REQ-023 Reset asserted mid-qualification SHALL abandon the pending change with no edge pulse.
REQ-024 raw_in SHALL be ignored while reset_n = 0; sampling resumes on the first edge with reset_n = 1.

Configuration
REQ-025 Macro PIN_DEBOUNCE_EDGE_EN defined: rise_p and fall_p ports exist.
- rise_p = 1 for exactly the one cycle in which d_out first reads 1 after a 0-to-1 toggle.
- fall_p is the same for a 1-to-0 toggle.
- Both pulses are registered and aligned with the new d_out value.
REQ-026 Macro not defined: rise_p and fall_p ports and their logic are absent; all other behaviour is identical.

Verification
REQ-027 STABLE_CYCLES=4, RESET_VAL=0: raw_in 0->1 held, first sampled on edge 1 -> d_out = 1 after edge 7; busy = 1 after edges 3..6; rise_p = 1 for one cycle after edge 7 (EDGE_EN build).
REQ-028 STABLE_CYCLES=4: raw_in high for 3 cycles, then low -> d_out stays 0; busy rises, then clears; no rise_p.
REQ-029 STABLE_CYCLES=4: raw_in bounces 1,0,1,0,1 each for 1 cycle, then holds 1 -> d_out = 1 exactly 7 edges after the final 0->1 sample.
REQ-030 reset_n = 0 for 1 cycle while busy = 1, with cnt = 3 -> after that edge d_out = 0, busy = 0, cnt = 0; the change then re-qualifies from scratch and takes a full 7 edges.
REQ-031 RESET_VAL=1, STABLE_CYCLES=1: after reset d_out = 1; raw_in 1->0 -> d_out = 0 after the 4th sampling edge; fall_p pulses once.
REQ-032 Build without PIN_DEBOUNCE_EDGE_EN -> rerun REQ-027..REQ-031; d_out and busy traces SHALL be identical and rise_p/fall_p SHALL be absent.
